// File: rtl/flash_b.sv
// flash_b: turns read / page-program / sector-erase requests into byte transfers for a byte-level SPI flash controller.
// Build option FLASH_B_POLL_TIMEOUT_EN bounds each status-poll phase to POLL_LIMIT reads and reports expiry as error.
module flash_b #(
  parameter int POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [1:0]  cmd,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        fa_write,
  output logic        fa_read,
  output logic        fa_deselect,
  output logic [7:0]  fa_din,
  input  logic [7:0]  fa_dout,
  input  logic        fa_done
);

  typedef enum logic [3:0] {
    IDLE, WREN, OPCODE, ADDR, WDATA, RDATA, POLL_OP, POLL_RD, FIN, WAIT
  } state_t;

  localparam logic [1:0] CMD_READ    = 2'd0;
  localparam logic [1:0] CMD_PROG    = 2'd1;
  localparam logic [1:0] CMD_ERASE   = 2'd2;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_PROG  = 8'h02;
  localparam logic [7:0] OP_ERASE = 8'hD8;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  state_t      state;
  state_t      ret_state;
  logic [1:0]  cmd_q;
  logic [23:0] addr_q;
  logic [8:0]  len_q;
  logic [8:0]  byte_cnt;
  logic [1:0]  addr_idx;
  logic        rd_is_data;
  logic        rd_is_poll;

  logic        start_ok;
  logic        bad_cmd;
  logic        last_byte;
  logic        poll_expired;
  logic [7:0]  opcode;
  logic [7:0]  addr_byte;

  // A start coinciding with a done strobe is dropped so a requester reacting late cannot double-issue.
  assign start_ok  = cmd_start && !busy && !done;
  assign bad_cmd   = (cmd == CMD_ILLEGAL) ||
                     ((cmd != CMD_ERASE) && ((len == 9'd0) || (len > 9'd256)));
  assign last_byte = (byte_cnt == (len_q - 9'd1));

  always_comb begin
    opcode = OP_ERASE;
    case (cmd_q)
      CMD_READ: opcode = OP_READ;
      CMD_PROG: opcode = OP_PROG;
      default:  opcode = OP_ERASE;
    endcase
    addr_byte = addr_q[7:0];
    case (addr_idx)
      2'd0:    addr_byte = addr_q[23:16];
      2'd1:    addr_byte = addr_q[15:8];
      default: addr_byte = addr_q[7:0];
    endcase
  end

`ifdef FLASH_B_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt;
  logic [16:0] poll_cnt_inc;

  assign poll_cnt_inc = {1'b0, poll_cnt} + 17'd1;
  assign poll_expired = ({15'd0, poll_cnt_inc} >= 32'(POLL_LIMIT));

  always_ff @(posedge clk) begin
    if (reset || start_ok)
      poll_cnt <= 16'd0;
    else if ((state == WAIT) && fa_done && rd_is_poll)
      poll_cnt <= poll_cnt_inc[15:0];
  end
`else
  logic unused_poll_limit;
  assign unused_poll_limit = ^POLL_LIMIT;
  assign poll_expired      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= 8'h00;
      wr_ready    <= 1'b0;
      fa_write    <= 1'b0;
      fa_read     <= 1'b0;
      fa_deselect <= 1'b0;
      fa_din      <= 8'h00;
      cmd_q       <= 2'd0;
      addr_q      <= 24'd0;
      len_q       <= 9'd0;
      byte_cnt    <= 9'd0;
      addr_idx    <= 2'd0;
      rd_is_data  <= 1'b0;
      rd_is_poll  <= 1'b0;
    end else begin
      fa_write <= 1'b0;
      fa_read  <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (bad_cmd) begin
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              error  <= 1'b0;
              busy   <= 1'b1;
              cmd_q  <= cmd;
              addr_q <= addr;
              len_q  <= len;
              state  <= (cmd == CMD_READ) ? OPCODE : WREN;
            end
          end
        end
        WREN: begin
          fa_write    <= 1'b1;
          fa_din      <= OP_WREN;
          fa_deselect <= 1'b1;
          ret_state   <= OPCODE;
          state       <= WAIT;
        end
        OPCODE: begin
          fa_write    <= 1'b1;
          fa_din      <= opcode;
          fa_deselect <= 1'b0;
          addr_idx    <= 2'd0;
          byte_cnt    <= 9'd0;
          ret_state   <= ADDR;
          state       <= WAIT;
        end
        ADDR: begin
          fa_write    <= 1'b1;
          fa_din      <= addr_byte;
          fa_deselect <= (addr_idx == 2'd2) && (cmd_q == CMD_ERASE);
          addr_idx    <= addr_idx + 2'd1;
          state       <= WAIT;
          if (addr_idx != 2'd2)
            ret_state <= ADDR;
          else if (cmd_q == CMD_READ)
            ret_state <= RDATA;
          else if (cmd_q == CMD_PROG)
            ret_state <= WDATA;
          else
            ret_state <= POLL_OP;
        end
        WDATA: begin
          // Chip select stays low across a stall because fa_deselect is only touched when a byte issues.
          if (wr_valid && wr_ready) begin
            wr_ready    <= 1'b0;
            fa_write    <= 1'b1;
            fa_din      <= wr_data;
            fa_deselect <= last_byte;
            byte_cnt    <= byte_cnt + 9'd1;
            ret_state   <= last_byte ? POLL_OP : WDATA;
            state       <= WAIT;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        RDATA: begin
          fa_read     <= 1'b1;
          fa_deselect <= last_byte;
          rd_is_data  <= 1'b1;
          byte_cnt    <= byte_cnt + 9'd1;
          ret_state   <= last_byte ? FIN : RDATA;
          state       <= WAIT;
        end
        POLL_OP: begin
          fa_write    <= 1'b1;
          fa_din      <= OP_RDSR;
          fa_deselect <= 1'b0;
          ret_state   <= POLL_RD;
          state       <= WAIT;
        end
        POLL_RD: begin
          fa_read     <= 1'b1;
          fa_deselect <= 1'b1;
          rd_is_poll  <= 1'b1;
          ret_state   <= POLL_OP;
          state       <= WAIT;
        end
        WAIT: begin
          if (fa_done) begin
            rd_is_data <= 1'b0;
            rd_is_poll <= 1'b0;
            if (rd_is_data) begin
              rd_data  <= fa_dout;
              rd_valid <= 1'b1;
            end
            // Status bit 0 is write-in-progress; keep polling while it is set.
            if (rd_is_poll) begin
              if (!fa_dout[0]) begin
                state <= FIN;
                done  <= 1'b1;
              end else if (poll_expired) begin
                state <= FIN;
                done  <= 1'b1;
                error <= 1'b1;
              end else begin
                state <= POLL_OP;
              end
            end else begin
              state    <= ret_state;
              done     <= (ret_state == FIN);
              wr_ready <= (ret_state == WDATA);
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_b.sv
// tb_flash_b: randomized bench with a byte-level flash model; expected byte streams are built from the command rules.
// Define FLASH_B_POLL_TIMEOUT_EN to also exercise the bounded-poll build (POLL_LIMIT=8).
module tb_flash_b;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [23:0] addr = 24'd0;
  logic [8:0]  len = 9'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, done, error;
  logic        fa_write, fa_read, fa_deselect;
  logic [7:0]  fa_din;
  logic [7:0]  fa_dout = 8'h00;
  logic        fa_done = 1'b0;

  flash_b #(.POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd(cmd), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error),
    .fa_write(fa_write), .fa_read(fa_read), .fa_deselect(fa_deselect), .fa_din(fa_din),
    .fa_dout(fa_dout), .fa_done(fa_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state: bytes seen on the flash side as {is_read, deselect, din}.
  logic [9:0] log_q[$];
  logic [9:0] exp_seq[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];
  logic [7:0] wr_q[$];
  int         gaps[$];
  int         wr_idx, gap_left;
  bit         wr_active = 1'b0;
  bit         wr_xfer = 1'b0;
  int         cur_wip, status_reads;
  logic [1:0] cur_cmd = 2'd0;
  int         done_cnt = 0;
  logic       err_at_done = 1'b0;
  int         pulse_viol, stab_viol, rdv_viol;
  bit         pending = 1'b0, pend_rd = 1'b0, rdv_expect = 1'b0;
  logic [7:0] pend_din = 8'h00;
  logic       pend_desel = 1'b0;
  int         lat = 0;
  logic [7:0] rb;

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        err_at_done = error;
      end
      if (rd_valid) got_rd.push_back(rd_data);
      if (rd_valid != rdv_expect) rdv_viol++;
    end
    rdv_expect = 1'b0;

    // Program data source with per-byte idle gaps.
    if (reset || !wr_active) begin
      wr_valid = 1'b0;
      wr_xfer  = 1'b0;
    end else begin
      if (wr_xfer) begin
        wr_idx++;
        gap_left = (wr_idx < wr_q.size()) ? gaps[wr_idx] : 0;
      end
      if (wr_idx < wr_q.size()) begin
        if (gap_left > 0) begin
          wr_valid = 1'b0;
          gap_left--;
        end else begin
          wr_valid = 1'b1;
          wr_data  = wr_q[wr_idx];
        end
      end else begin
        wr_valid = 1'b0;
      end
      wr_xfer = wr_valid && wr_ready;
    end

    // Byte-level flash controller model with random latency.
    if (reset) begin
      pending = 1'b0;
      fa_done = 1'b0;
    end else begin
      fa_done = 1'b0;
      if (fa_write || fa_read) begin
        if (pending || (fa_write && fa_read)) pulse_viol++;
        log_q.push_back(fa_read ? {1'b1, fa_deselect, 8'h00} : {1'b0, fa_deselect, fa_din});
        pend_rd    = fa_read;
        pend_din   = fa_din;
        pend_desel = fa_deselect;
        pending    = 1'b1;
        lat        = $urandom_range(0, 3);
      end else if (pending && ((fa_din != pend_din) || (fa_deselect != pend_desel))) begin
        stab_viol++;
      end
      if (pending) begin
        if (lat == 0) begin
          fa_done = 1'b1;
          pending = 1'b0;
          rb = 8'($urandom);
          if (pend_rd && (cur_cmd != 2'd0)) begin
            rb[0] = (status_reads < cur_wip);
            status_reads++;
          end else if (pend_rd) begin
            exp_rd.push_back(rb);
            rdv_expect = 1'b1;
          end
          fa_dout = rb;
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [9:0] w_ent(input logic [7:0] d, input logic ds);
    return {1'b0, ds, d};
  endfunction

  function automatic logic [9:0] r_ent(input logic ds);
    return {1'b1, ds, 8'h00};
  endfunction

  task automatic build_expect(input logic [1:0] c, input logic [23:0] a, input int l, input int wip,
                              output bit e);
    int npoll;
    exp_seq.delete();
    e = 1'b0;
    npoll = wip + 1;
`ifdef FLASH_B_POLL_TIMEOUT_EN
    if (wip >= LIMIT) begin
      npoll = LIMIT;
      e = 1'b1;
    end
`endif
    if (c != 2'd0) exp_seq.push_back(w_ent(8'h06, 1'b1));
    exp_seq.push_back(w_ent((c == 2'd0) ? 8'h03 : (c == 2'd1) ? 8'h02 : 8'hD8, 1'b0));
    exp_seq.push_back(w_ent(a[23:16], 1'b0));
    exp_seq.push_back(w_ent(a[15:8], 1'b0));
    exp_seq.push_back(w_ent(a[7:0], c == 2'd2));
    if (c == 2'd0)
      for (int i = 0; i < l; i++) exp_seq.push_back(r_ent(i == l - 1));
    if (c == 2'd1)
      for (int i = 0; i < l; i++) exp_seq.push_back(w_ent(wr_q[i], i == l - 1));
    if (c != 2'd0)
      for (int p = 0; p < npoll; p++) begin
        exp_seq.push_back(w_ent(8'h05, 1'b0));
        exp_seq.push_back(r_ent(1'b1));
      end
  endtask

  task automatic run_cmd(input string nm, input logic [1:0] c, input logic [23:0] a, input logic [8:0] l,
                         input int wip, input int gap_max, input int stall_idx);
    int d0, n, ln;
    bit e;
    ln = int'(l);
    log_q.delete(); exp_rd.delete(); got_rd.delete(); wr_q.delete(); gaps.delete();
    pulse_viol = 0; stab_viol = 0; rdv_viol = 0;
    status_reads = 0; cur_wip = wip; cur_cmd = c;
    if (c == 2'd1)
      for (int i = 0; i < ln; i++) begin
        wr_q.push_back(8'($urandom));
        gaps.push_back((i == stall_idx) ? 10 : $urandom_range(0, gap_max));
      end
    wr_idx = 0;
    gap_left = (gaps.size() > 0) ? gaps[0] : 0;
    wr_xfer = 1'b0;
    wr_active = (c == 2'd1);
    build_expect(c, a, ln, wip, e);
    d0 = done_cnt;
    cmd = c; addr = a; len = l; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd = 2'($urandom); addr = 24'($urandom); len = 9'($urandom);
    check_eq({nm, "_busy_rise"}, busy, 1);
    check_eq({nm, "_err_clear"}, error, 0);
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      tick();
      n++;
    end
    check_eq({nm, "_done_seen"}, done_cnt != d0, 1);
    tick();
    check_eq({nm, "_busy_fall"}, busy, 0);
    repeat (3) tick();
    check_eq({nm, "_done_once"}, done_cnt, d0 + 1);
    check_eq({nm, "_err_at_done"}, err_at_done, e);
    check_eq({nm, "_err_held"}, error, e);
    check_eq({nm, "_seq_len"}, log_q.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s_seq%0d", nm, i), log_q[i], exp_seq[i]);
    check_eq({nm, "_rd_cnt"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      check_eq($sformatf("%s_rd%0d", nm, i), got_rd[i], exp_rd[i]);
    check_eq({nm, "_pulse_viol"}, pulse_viol, 0);
    check_eq({nm, "_stable_viol"}, stab_viol, 0);
    check_eq({nm, "_rdv_timing"}, rdv_viol, 0);
    wr_active = 1'b0;
  endtask

  task automatic run_illegal(input string nm, input logic [1:0] c, input logic [8:0] l);
    int d0;
    log_q.delete();
    cur_cmd = c;
    d0 = done_cnt;
    cmd = c; len = l; addr = 24'($urandom); cmd_start = 1'b1;
    tick();
    check_eq({nm, "_done"}, done, 1);
    check_eq({nm, "_error"}, error, 1);
    check_eq({nm, "_busy"}, busy, 0);
    // A legal start presented while done is high must be dropped.
    cmd = 2'd0; len = 9'd4; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq({nm, "_ign_busy"}, busy, 0);
    check_eq({nm, "_done_pulse"}, done, 0);
    repeat (10) tick();
    check_eq({nm, "_no_traffic"}, log_q.size(), 0);
    check_eq({nm, "_done_once"}, done_cnt, d0 + 1);
    check_eq({nm, "_err_held"}, error, 1);
  endtask

  task automatic run_reset_mid();
    int d0, n;
    log_q.delete();
    cur_cmd = 2'd0; cur_wip = 0;
    d0 = done_cnt;
    cmd = 2'd0; addr = 24'hABCDEF; len = 9'd8; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    check_eq("rst_reached_addr", log_q.size(), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fa_write", fa_write, 0);
    repeat (20) tick();
    check_eq("rst_busy_idle", busy, 0);
    check_eq("rst_no_done", done_cnt, d0);
    check_eq("rst_no_more_bytes", log_q.size(), 2);
    check_eq("rst_no_rd_valid", rdv_viol, 0);
  endtask

  initial begin
    pulse_viol = 0; stab_viol = 0; rdv_viol = 0;
    cur_wip = 0; status_reads = 0; wr_idx = 0; gap_left = 0;
    reset = 1'b1;
    repeat (3) tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_error", error, 0);
    check_eq("reset_rd_valid", rd_valid, 0);
    check_eq("reset_wr_ready", wr_ready, 0);
    check_eq("reset_fa_write", fa_write, 0);
    check_eq("reset_fa_read", fa_read, 0);
    check_eq("reset_fa_deselect", fa_deselect, 0);
    check_eq("reset_fa_din", fa_din, 0);
    reset = 1'b0;
    repeat (2) tick();

    run_cmd("rd_123456", 2'd0, 24'h123456, 9'd2, 0, 0, -1);
    run_cmd("pg_stall", 2'd1, 24'($urandom), 9'd3, 0, 0, 1);
    run_cmd("er_wip4", 2'd2, 24'($urandom), 9'd0, 4, 0, -1);
    run_illegal("ill_cmd3", 2'd3, 9'd5);
    run_illegal("ill_len0", 2'd0, 9'd0);
    run_illegal("ill_len257", 2'd1, 9'd257);
    run_cmd("rd_len256", 2'd0, 24'($urandom), 9'd256, 0, 0, -1);
    run_cmd("pg_len1", 2'd1, 24'($urandom), 9'd1, 2, 2, -1);
    run_reset_mid();
    for (int k = 0; k < 15; k++)
      run_cmd($sformatf("rnd%0d", k), 2'($urandom_range(0, 2)), 24'($urandom),
              9'($urandom_range(1, 24)), $urandom_range(0, 3), 3, -1);
`ifdef FLASH_B_POLL_TIMEOUT_EN
    run_cmd("er_timeout", 2'd2, 24'($urandom), 9'd1, 1000, 0, -1);
    run_cmd("pg_wip7", 2'd1, 24'($urandom), 9'd2, LIMIT - 1, 1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_b.md
FLASH_B -- requirements
Module: flash_b

Interface
REQ-001 Parameter POLL_LIMIT, default 65535, maximum status reads per poll phase (used only when FLASH_B_POLL_TIMEOUT_EN is defined).
REQ-002 clk  input  1  clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 cmd_start  input  1  one-cycle request to start a command; ignored while busy=1.
REQ-005 cmd  input  2  0=read, 1=page program, 2=sector erase, 3=illegal; sampled on cmd_start.
REQ-006 addr  input  24  flash byte address; sampled on cmd_start.
REQ-007 len  input  9  byte count, 1..256; sampled on cmd_start; ignored for erase.
REQ-008 wr_data  input  8  program data byte.
REQ-009 wr_valid  input  1  wr_data valid.
REQ-010 wr_ready  output  1  block accepts wr_data this cycle.
REQ-011 rd_data  output  8  read data byte.
REQ-012 rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-013 busy  output  1  command in progress.
REQ-014 done  output  1  one-cycle completion strobe.
REQ-015 error  output  1  set with done on failure; held until next accepted cmd_start.
REQ-016 fa_write, fa_read  output  1 each  one-cycle byte write/read request to the byte-level flash controller.
REQ-017 fa_deselect  output  1  raise chip select after the requested byte.
REQ-018 fa_din  output  8  byte to transmit.
REQ-019 fa_dout  input  8  received byte, valid with fa_done.
REQ-020 fa_done  input  1  byte-level completion strobe.

Function
REQ-021 States: IDLE, WREN, OPCODE, ADDR, WDATA, RDATA, POLL_OP, POLL_RD, FIN; each byte issue moves to WAIT, which returns to the recorded next state on fa_done.
REQ-022 At most one fa_write/fa_read pulse is issued per fa_done; fa_din and fa_deselect stay stable from pulse until fa_done.
REQ-023 Read: 0x03, addr[23:16], addr[15:8], addr[7:0] with fa_deselect=0, then len reads; only the last read has fa_deselect=1.
REQ-024 Each read fa_done drives rd_data=fa_dout and rd_valid=1 in the next cycle.
REQ-025 Program: 0x06 with fa_deselect=1; 0x02 plus 3 address bytes; then len data bytes, last with fa_deselect=1; then poll.
REQ-026 WDATA asserts wr_ready until wr_valid=1; the byte transfers on wr_valid&wr_ready and is issued next cycle; chip select stays low while stalled.
REQ-027 Erase: 0x06 with fa_deselect=1; 0xD8 plus 3 address bytes, last with fa_deselect=1; then poll.
REQ-028 Poll: 0x05 with fa_deselect=0, one read with fa_deselect=1; repeat while fa_dout[0]=1; on 0 go to FIN.
REQ-029 FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-030 cmd=3, or len=0 or len>256 for read/program: no flash traffic; done=1 and error=1 one cycle after cmd_start.
REQ-031 cmd_start with done in the same cycle is ignored; busy rises the cycle after an accepted cmd_start.

Reset
REQ-032 Reset returns to IDLE and clears busy, done, error, rd_valid, wr_ready, fa_write, fa_read, fa_deselect and fa_din.
REQ-033 Reset mid-command abandons the command with no done strobe; the byte-level controller is reset by the same reset.

Configuration
REQ-034 With FLASH_B_POLL_TIMEOUT_EN defined, a 16-bit counter counts status reads per poll phase; reaching POLL_LIMIT with WIP still 1 goes to FIN with error=1.
REQ-035 Without FLASH_B_POLL_TIMEOUT_EN, polling continues indefinitely and error arises only from REQ-030.

Verification
REQ-036 Read addr=0x123456, len=2 -> fa_din 03,12,34,56, two reads, deselect only on the second, two rd_valid, done, error=0.
REQ-037 Program len=3, wr_valid held low 10 cycles before byte 2 -> WREN 06 deselected, 02+address, 3 data bytes in order, no extra fa_write during the stall.
REQ-038 Erase with model WIP=1 for 4 polls then 0 -> five 05/read pairs, then done, error=0.
REQ-039 FLASH_B_POLL_TIMEOUT_EN, POLL_LIMIT=8, WIP stuck at 1 -> exactly 8 polls, then done=1, error=1.
REQ-040 cmd=3 and len=0 read -> done=1, error=1, no fa_write/fa_read; reset during ADDR -> IDLE, busy=0, no done.
